// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the sequential ALU-control block: alu_op values,
// R-type funct_ctrl codes, alu_funct output codes and the FSM state type.
package alu_ctrl_pkg;

    // alu_op encodings coming from the control unit
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_SLT   = 2'b11;

    // R-type funct_ctrl values understood by the decoder
    localparam logic [5:0] FN_ADDU = 6'b001011;
    localparam logic [5:0] FN_SUBU = 6'b001101;
    localparam logic [5:0] FN_SLL  = 6'b100110;
    localparam logic [5:0] FN_SLLV = 6'b110110;

    // Decoded alu_funct codes presented on the output
    localparam logic [5:0] AF_ADD     = 6'b001001;
    localparam logic [5:0] AF_SUB     = 6'b001010;
    localparam logic [5:0] AF_SLL     = 6'b100001;
    localparam logic [5:0] AF_SLLV    = 6'b110101;
    localparam logic [5:0] AF_SLT     = 6'b101010;
    localparam logic [5:0] AF_ILLEGAL = 6'b000000;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational decoder: {alu_op, funct_ctrl} -> {alu_funct, illegal, is_shift}.
module alu_funct_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct_ctrl,
    output logic [5:0] o_alu_funct,
    output logic       o_illegal,
    output logic       o_is_shift
);

    // Map the control-unit request onto an ALU function code
    always_comb begin
        o_alu_funct = AF_ILLEGAL;
        o_illegal   = 1'b0;
        o_is_shift  = 1'b0;
        case (i_alu_op)
            OP_ADD: o_alu_funct = AF_ADD;
            OP_SUB: o_alu_funct = AF_SUB;
            OP_SLT: o_alu_funct = AF_SLT;
            default: begin
                case (i_funct_ctrl)
                    FN_ADDU: o_alu_funct = AF_ADD;
                    FN_SUBU: o_alu_funct = AF_SUB;
                    FN_SLL: begin
                        o_alu_funct = AF_SLL;
                        o_is_shift  = 1'b1;
                    end
                    FN_SLLV: begin
                        o_alu_funct = AF_SLLV;
                        o_is_shift  = 1'b1;
                    end
                    default: begin
                        o_alu_funct = AF_ILLEGAL;
                        o_illegal   = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Sequential ALU-control: decodes the request, runs add/sub/slt in one EXEC
// cycle and SLL/SLLV on an iterative shifter (SHIFT_STEP bits per cycle).
// Handshakes: a side transfers on in_valid && in_ready; the result side
// transfers on out_valid && out_ready, and out_valid/result hold until then.
// Optional build macro: ALU_FLAGS_EN adds out_zero / out_ovf flag outputs.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SHAMT_W    = $clog2(DATA_W),
    parameter int SHIFT_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct_ctrl,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [5:0]        alu_funct,
    output logic              illegal,
`ifdef ALU_FLAGS_EN
    output logic              out_zero,
    output logic              out_ovf,
`endif
    output logic [1:0]        dbg_state
);

    // Counter is one bit wider so it can hold SHIFT_STEP == DATA_W
    localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W+1)'(SHIFT_STEP);

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [SHAMT_W:0]    r_rem;
    logic [5:0]          r_funct;
    logic                r_illegal;
    logic [DATA_W-1:0]   r_result;

    logic [5:0]          w_dec_funct;
    logic                w_dec_illegal;
    logic                w_dec_shift;
    logic                w_accept;
    logic [SHAMT_W-1:0]  w_amt;
    logic [SHAMT_W:0]    w_step;
    logic                w_last_step;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic                w_slt;
    logic [DATA_W-1:0]   w_exec_res;

    alu_funct_decode u_decode (
        .i_alu_op     (alu_op),
        .i_funct_ctrl (funct_ctrl),
        .o_alu_funct  (w_dec_funct),
        .o_illegal    (w_dec_illegal),
        .o_is_shift   (w_dec_shift)
    );

    // Ready is forced low while reset is asserted
    assign in_ready  = rst_n && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign alu_funct = r_funct;
    assign illegal   = r_illegal;
    assign dbg_state = r_state;

    // SLLV takes its amount from src_a, SLL from the shamt field
    assign w_amt       = (w_dec_funct == AF_SLLV) ? src_a[SHAMT_W-1:0] : shamt;
    // Last step shifts only what remains, so the shifter never overshoots
    assign w_step      = (r_rem >= STEP_C) ? STEP_C : r_rem;
    assign w_last_step = (r_rem <= STEP_C);
    assign w_shifted   = r_b << w_step;

    assign w_sum  = r_a + r_b;
    assign w_diff = r_a - r_b;
    assign w_slt  = ($signed(r_a) < $signed(r_b));

    // One-cycle result select; illegal requests produce zero
    always_comb begin
        w_exec_res = '0;
        case (r_funct)
            AF_ADD:  w_exec_res = w_sum;
            AF_SUB:  w_exec_res = w_diff;
            AF_SLT:  w_exec_res = {{(DATA_W-1){1'b0}}, w_slt};
            default: w_exec_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = w_dec_shift ? SHIFT : EXEC;
            end
            EXEC: w_next = DONE;
            SHIFT: begin
                if (w_last_step) w_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (w_accept) w_next = w_dec_shift ? SHIFT : EXEC;
                    else          w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture at accept, iterative shifting, decoded-code registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_funct   <= AF_ILLEGAL;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_a       <= src_a;
            r_b       <= src_b;
            r_rem     <= {1'b0, w_amt};
            r_funct   <= w_dec_funct;
            r_illegal <= w_dec_illegal;
        end else if (r_state == SHIFT) begin
            r_b   <= w_shifted;
            r_rem <= r_rem - w_step;
        end
    end

    // Result register loads only when an operation completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if (r_state == EXEC) begin
            r_result <= w_exec_res;
        end else if ((r_state == SHIFT) && w_last_step) begin
            r_result <= w_shifted;
        end
    end

`ifdef ALU_FLAGS_EN
    logic w_ovf;

    // Signed overflow: operands agree in sign (add) / differ (sub) and the result flips
    always_comb begin
        w_ovf = 1'b0;
        case (r_funct)
            AF_ADD:  w_ovf = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);
            AF_SUB:  w_ovf = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_diff[DATA_W-1] != r_a[DATA_W-1]);
            default: w_ovf = 1'b0;
        endcase
    end

    // Flags registered alongside the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (r_state == EXEC) begin
            out_zero <= (w_exec_res == '0);
            out_ovf  <= w_ovf;
        end else if ((r_state == SHIFT) && w_last_step) begin
            out_zero <= (w_shifted == '0);
            out_ovf  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq (DATA_W=32, SHIFT_STEP=1).
// Build with ALU_FLAGS_EN defined to also check out_zero / out_ovf.
module tb_alu_ctrl_seq;

  localparam int DW   = 32;
  localparam int SW   = 5;
  localparam int STEP = 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    alu_op;
  logic [5:0]    funct_ctrl;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic [SW-1:0] shamt;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic [5:0]    alu_funct;
  logic          illegal;
  logic [1:0]    dbg_state;
`ifdef ALU_FLAGS_EN
  logic          out_zero;
  logic          out_ovf;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  alu_ctrl_seq #(.DATA_W(DW), .SHIFT_STEP(STEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .funct_ctrl (funct_ctrl),
    .src_a      (src_a),
    .src_b      (src_b),
    .shamt      (shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .alu_funct  (alu_funct),
    .illegal    (illegal),
`ifdef ALU_FLAGS_EN
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- model ----------------
  typedef struct {
    logic [DW-1:0] res;
    logic [5:0]    fn;
    logic          ill;
    logic          zero;
    logic          ovf;
    int            lat;
    int            acc;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic seen = 1'b0;
  int cur_lat = 0;
  int last_lat = 0;
  logic [DW-1:0] last_res;
  logic [5:0]    last_fn;
  logic          last_ill;
  int acc_prev = 0;
  int acc_last = 0;

  // Result of a request from the arithmetic meaning of each operation
  function automatic exp_t model(input logic [1:0] o, input logic [5:0] f,
                                 input logic [DW-1:0] xa, input logic [DW-1:0] xb,
                                 input logic [SW-1:0] xs);
    exp_t e;
    int kind;  // 0 add, 1 sub, 2 slt, 3 sll, 4 sllv, 5 illegal
    longint sa, sb, sr;
    int amt;
    e = '{default: 0};
    case (o)
      2'b00: kind = 0;
      2'b01: kind = 1;
      2'b11: kind = 2;
      default: begin
        case (f)
          6'b001011: kind = 0;
          6'b001101: kind = 1;
          6'b100110: kind = 3;
          6'b110110: kind = 4;
          default:   kind = 5;
        endcase
      end
    endcase
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    e.lat = 2;
    case (kind)
      0: begin
        sr = sa + sb;
        e.res = xa + xb;
        e.fn = 6'b001001;
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      1: begin
        sr = sa - sb;
        e.res = xa - xb;
        e.fn = 6'b001010;
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2: begin
        e.res = (sa < sb) ? 1 : 0;
        e.fn = 6'b101010;
      end
      3, 4: begin
        amt = (kind == 3) ? int'(xs) : int'(xa % DW);
        e.res = xb << amt;
        e.fn = (kind == 3) ? 6'b100001 : 6'b110101;
        e.lat = 1 + ((amt == 0) ? 1 : (amt + STEP - 1) / STEP);
      end
      default: begin
        e.res = '0;
        e.fn = 6'b000000;
        e.ill = 1'b1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            cur_lat = cyc - exp_q[0].acc + 1;
            check("latency", cur_lat, exp_q[0].lat);
          end
          check("result", result, exp_q[0].res);
          check("alu_funct", alu_funct, exp_q[0].fn);
          check("illegal", illegal, exp_q[0].ill);
`ifdef ALU_FLAGS_EN
          check("out_zero", out_zero, exp_q[0].zero);
          check("out_ovf", out_ovf, exp_q[0].ovf);
`endif
          if (out_ready) begin
            last_res = result;
            last_fn  = alu_funct;
            last_ill = illegal;
            last_lat = cur_lat;
            void'(exp_q.pop_front());
            seen = 1'b0;
            done_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] o, input logic [5:0] f,
                      input logic [DW-1:0] xa, input logic [DW-1:0] xb,
                      input logic [SW-1:0] xs);
    exp_t e;
    int n;
    e = model(o, f, xa, xb, xs);
    alu_op = o; funct_ctrl = f; src_a = xa; src_b = xb; shamt = xs;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.acc = cyc;
    exp_q.push_back(e);
    acc_prev = acc_last;
    acc_last = cyc;
    in_valid = 1'b0;
    // Scramble inputs: the in-flight op must not see them
    alu_op = 2'($urandom_range(0, 3));
    funct_ctrl = 6'($urandom_range(0, 63));
    src_a = $urandom;
    src_b = $urandom;
    shamt = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) check("done_timeout", done_cnt, target);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  int base;
  int gap;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    alu_op = '0; funct_ctrl = '0; src_a = '0; src_b = '0; shamt = '0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_alu_funct", alu_funct, 0);
    check("rst_illegal", illegal, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("post_rst_in_ready", in_ready, 1);

    // 1. add 7+5
    base = done_cnt;
    send(2'b00, 6'h00, 32'd7, 32'd5, 5'd0);
    wait_done(base + 1);
    check("t1_result", last_res, 32'd12);
    check("t1_funct", last_fn, 6'b001001);
    check("t1_lat", last_lat, 2);

    // 2. sub 3-5, then an overflowing sub
    base = done_cnt;
    send(2'b01, 6'h00, 32'd3, 32'd5, 5'd0);
    wait_done(base + 1);
    check("t2_result", last_res, 32'hFFFF_FFFE);
    check("t2_funct", last_fn, 6'b001010);
    base = done_cnt;
    send(2'b01, 6'h00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    wait_done(base + 1);
    check("t2_ovf_result", last_res, 32'h8000_0000);

    // 3. SLL by 31 and by 0
    base = done_cnt;
    send(2'b10, 6'b100110, 32'h0, 32'h1, 5'd31);
    wait_done(base + 1);
    check("t3_sll31_result", last_res, 32'h8000_0000);
    check("t3_sll31_lat", last_lat, 32);
    base = done_cnt;
    send(2'b10, 6'b100110, 32'h0, 32'h1, 5'd0);
    wait_done(base + 1);
    check("t3_sll0_result", last_res, 32'h1);
    check("t3_sll0_lat", last_lat, 2);

    // 4. SLLV amount 4 with the consumer stalled
    base = done_cnt;
    out_ready = 1'b0;
    send(2'b10, 6'b110110, 32'h24, 32'hF, 5'd0);
    for (int i = 0; i < 50 && out_valid !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall_out_valid", out_valid, 1);
      check("t4_stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(base + 1);
    check("t4_result", last_res, 32'hF0);

    // 5. slt, illegal funct, R-type ADDU/SUBU, slt false
    base = done_cnt;
    send(2'b11, 6'h00, 32'hFFFF_FFFF, 32'h1, 5'd0);
    wait_done(base + 1);
    check("t5_slt_result", last_res, 32'h1);
    base = done_cnt;
    send(2'b10, 6'b111111, 32'h1234, 32'h5678, 5'd3);
    wait_done(base + 1);
    check("t5_ill_flag", last_ill, 1);
    check("t5_ill_result", last_res, 32'h0);
    check("t5_ill_funct", last_fn, 6'b000000);
    base = done_cnt;
    send(2'b10, 6'b001011, 32'hFFFF_FFFF, 32'h2, 5'd0);
    send(2'b10, 6'b001101, 32'h10, 32'h20, 5'd0);
    send(2'b11, 6'h00, 32'h5, 32'hFFFF_FFF0, 5'd0);
    wait_done(base + 3);
    check("t5_slt_false", last_res, 32'h0);

    // Back-to-back adds: one accept every two cycles
    base = done_cnt;
    send(2'b00, 6'h00, 32'd100, 32'd23, 5'd0);
    send(2'b00, 6'h00, 32'd1, 32'd2, 5'd0);
    gap = acc_last - acc_prev;
    check("b2b_accept_gap", gap, 2);
    wait_done(base + 2);
    check("b2b_result", last_res, 32'd3);

    // A few random requests through the model
    base = done_cnt;
    for (int i = 0; i < 8; i++) begin
      logic [5:0] f;
      case ($urandom_range(0, 4))
        0: f = 6'b001011;
        1: f = 6'b001101;
        2: f = 6'b100110;
        3: f = 6'b110110;
        default: f = 6'($urandom_range(0, 63));
      endcase
      send(2'($urandom_range(0, 3)), f, $urandom, $urandom, 5'($urandom_range(0, 31)));
    end
    wait_done(base + 8);

    // 6. reset in the middle of a shift
    send(2'b10, 6'b100110, 32'h0, 32'h3, 5'd20);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_result", result, 0);
    check("t6_rst_in_ready", in_ready, 0);
    check("t6_rst_alu_funct", alu_funct, 0);
    exp_q.delete();
    seen = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = done_cnt;
    send(2'b00, 6'h00, 32'd40, 32'd2, 5'd0);
    wait_done(base + 1);
    check("t6_after_rst_result", last_res, 32'd42);
    check("t6_after_rst_lat", last_lat, 2);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
